// File: rtl/def.sv
// ---------------------------------------------------------------------------
// dmem_ctrl_pkg - shared funct3 codes and controller state encoding | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array - 32-bit word storage, byte-enable write, async read | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    // Contents are deliberately not reset.
    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl - RV32I load/store data-memory controller with wait states | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        w_accept, w_access, w_fault, w_mem_we;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_word, w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign w_accept  = req_valid & req_ready;
    assign w_access  = (state_q == ST_BUSY) && (cnt_q == 4'd0);

    // Illegal encodings, misalignment and out-of-range all collapse into one fault.
    always_comb begin
        w_fault = 1'b0;
        if (we_q ? (f3_q > F3_W) : (f3_q == 3'd3 || f3_q == 3'd6 || f3_q == 3'd7))
            w_fault = 1'b1;
        if ((f3_q == F3_H || f3_q == F3_HU) && addr_q[0])
            w_fault = 1'b1;
        if (f3_q == F3_W && addr_q[1:0] != 2'b00)
            w_fault = 1'b1;
        if ({1'b0, addr_q} >= BYTE_LIMIT)
            w_fault = 1'b1;
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = wdata_q;
        case (f3_q)
            F3_B: begin
                w_be    = 4'b0001 << addr_q[1:0];
                w_wdata = {4{wdata_q[7:0]}};
            end
            F3_H: begin
                w_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata_q[15:0]}};
            end
            F3_W:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_mem_we = w_access & we_q & ~w_fault;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (w_mem_we),
        .be_i    (w_be),
        .addr_i  (addr_q[AW+1:2]),
        .wdata_i (w_wdata),
        .rdata_o (w_word)
    );

    assign w_byte = w_word[{addr_q[1:0], 3'b000} +: 8];
    assign w_half = addr_q[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = 32'd0;
        if (!we_q && !w_fault) begin
            case (f3_q)
                F3_B:    w_load = {{24{w_byte[7]}}, w_byte};
                F3_H:    w_load = {{16{w_half[15]}}, w_half};
                F3_W:    w_load = w_word;
                F3_BU:   w_load = {24'd0, w_byte};
                F3_HU:   w_load = {16'd0, w_half};
                default: w_load = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_BUSY;
                    cnt_d   = 4'(LATENCY);
                end
            end
            ST_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                    rdata_d = w_load;
                    err_d   = w_fault;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (w_accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_ctrl - directed bench for dmem_ctrl at LATENCY 1, 3 and 0 | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [2:0]  req_f3    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    // DUT 0: LATENCY=1, DUT 1: LATENCY=3, DUT 2: LATENCY=0
    int exp_lat [3] = '{2, 4, 1};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 0;
        dmem_ctrl #(
            .DEPTH_WORDS (1024),
            .LATENCY     (LAT)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_funct3 (req_f3[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g])
        );
    end

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = nm; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // Returns at the negedge following the acceptance edge.
    task automatic accept(input int d, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_f3[d]    = f3;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) chk($sformatf("dut%0d accept_timeout", d), 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        chk($sformatf("dut%0d busy_req_ready", d), 32'(req_ready[d]), 32'd0);
    endtask

    task automatic collect(input int d, input int hold, input string nm,
                           output logic [31:0] rdata, output logic err);
        int lat = 0;
        while (!rsp_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s latency", nm), 32'(lat), 32'(exp_lat[d]));
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk($sformatf("%s hold%0d rsp_valid", nm, i), 32'(rsp_valid[d]), 32'd1);
            chk($sformatf("%s hold%0d rsp_rdata", nm, i), rsp_rdata[d], rdata);
            chk($sformatf("%s hold%0d rsp_err", nm, i), 32'(rsp_err[d]), 32'(err));
            chk($sformatf("%s hold%0d req_ready", nm, i), 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk($sformatf("%s idle_after_hs", nm), 32'(req_ready[d]), 32'd1);
        chk($sformatf("%s valid_drop", nm), 32'(rsp_valid[d]), 32'd0);
    endtask

    task automatic xact(input int d, input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        accept(d, we, f3, addr, wdata);
        collect(d, 0, nm, rd, er);
        chk($sformatf("%s rdata", nm), rd, exp_rdata);
        chk($sformatf("%s err", nm), 32'(er), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          n;

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0; req_valid[d] = 1'b0; rsp_ready[d] = 1'b0;
            req_we[d] = 1'b0; req_f3[d] = 3'd0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d reset req_ready", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("dut%0d reset rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("dut%0d reset rsp_rdata", d), rsp_rdata[d], 32'd0);
            chk($sformatf("dut%0d reset rsp_err", d), 32'(rsp_err[d]), 32'd0);
            rst[d] = 1'b1;
        end

        add("sw_deadbeef",  1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        0);
        add("lw_10_a",      0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 0);
        add("sb_a5_13",     1, 3'd0, 32'h13,   32'h000000A5, 32'h0,        0);
        add("lw_10_b",      0, 3'd2, 32'h10,   32'h0,        32'hA5ADBEEF, 0);
        add("lb_13",        0, 3'd0, 32'h13,   32'h0,        32'hFFFFFFA5, 0);
        add("lbu_13",       0, 3'd4, 32'h13,   32'h0,        32'h000000A5, 0);
        add("sh_1234_12",   1, 3'd1, 32'h12,   32'h00001234, 32'h0,        0);
        add("lw_10_c",      0, 3'd2, 32'h10,   32'h0,        32'h1234BEEF, 0);
        add("lh_11_mis",    0, 3'd1, 32'h11,   32'h0,        32'h0,        1);
        add("lw_10_d",      0, 3'd2, 32'h10,   32'h0,        32'h1234BEEF, 0);
        add("sw_oob",       1, 3'd2, 32'h1000, 32'h11111111, 32'h0,        1);
        add("lw_oob",       0, 3'd2, 32'h1000, 32'h0,        32'h0,        1);
        add("ld_f3_3",      0, 3'd3, 32'h10,   32'h0,        32'h0,        1);
        add("lh_12",        0, 3'd1, 32'h12,   32'h0,        32'h00001234, 0);
        add("lb_10",        0, 3'd0, 32'h10,   32'h0,        32'hFFFFFFEF, 0);
        add("lhu_10",       0, 3'd5, 32'h10,   32'h0,        32'h0000BEEF, 0);
        add("lh_10",        0, 3'd1, 32'h10,   32'h0,        32'hFFFFBEEF, 0);
        add("lbu_11",       0, 3'd4, 32'h11,   32'h0,        32'h000000BE, 0);
        add("sw_mis_12",    1, 3'd2, 32'h12,   32'h77777777, 32'h0,        1);
        add("sh_mis_11",    1, 3'd1, 32'h11,   32'h7777,     32'h0,        1);
        add("st_f3_3",      1, 3'd3, 32'h10,   32'h55555555, 32'h0,        1);
        add("st_f3_4",      1, 3'd4, 32'h10,   32'h55555555, 32'h0,        1);
        add("lw_10_e",      0, 3'd2, 32'h10,   32'h0,        32'h1234BEEF, 0);
        add("ld_f3_6",      0, 3'd6, 32'h10,   32'h0,        32'h0,        1);
        add("ld_f3_7",      0, 3'd7, 32'h10,   32'h0,        32'h0,        1);
        add("sw_last",      1, 3'd2, 32'hFFC,  32'hCAFEF00D, 32'h0,        0);
        add("lw_last",      0, 3'd2, 32'hFFC,  32'h0,        32'hCAFEF00D, 0);
        add("lb_oob",       0, 3'd0, 32'h1003, 32'h0,        32'h0,        1);

        foreach (vecs[i])
            xact(0, vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr,
                 vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);

        // Backpressure: response must hold for three stalled cycles.
        accept(0, 1'b0, 3'd2, 32'hFFC, 32'h0);
        collect(0, 3, "bp_lw_last", rd, er);
        chk("bp rdata", rd, 32'hCAFEF00D);
        chk("bp err", 32'(er), 32'd0);

        // Reset while a store waits in BUSY must not commit it.
        xact(1, "d1_sw_init", 1'b1, 3'd2, 32'h10, 32'h55AA00FF, 32'h0, 1'b0);
        accept(1, 1'b1, 3'd2, 32'h10, 32'h0);
        rst[1] = 1'b0;
        #1;
        chk("rst_busy rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rst_busy req_ready", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        rst[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rst_busy quiet%0d", i), 32'(rsp_valid[1]), 32'd0);
        end
        xact(1, "d1_lw_after_rst", 1'b0, 3'd2, 32'h10, 32'h0, 32'h55AA00FF, 1'b0);

        // Reset while a response is pending drops it.
        accept(1, 1'b0, 3'd2, 32'h10, 32'h0);
        n = 0;
        while (!rsp_valid[1] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_resp reached", 32'(rsp_valid[1]), 32'd1);
        rst[1] = 1'b0;
        #1;
        chk("rst_resp rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rst_resp rsp_rdata", rsp_rdata[1], 32'd0);
        chk("rst_resp req_ready", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        chk("rst_resp stays_idle", 32'(rsp_valid[1]), 32'd0);
        xact(1, "d1_lbu_12", 1'b0, 3'd4, 32'h12, 32'h0, 32'h000000AA, 1'b0);

        // Zero wait states.
        xact(2, "d2_sb_80", 1'b1, 3'd0, 32'h20, 32'h00000080, 32'h0, 1'b0);
        xact(2, "d2_lb_20", 1'b0, 3'd0, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0);
        xact(2, "d2_lbu_20", 1'b0, 3'd4, 32'h20, 32'h0, 32'h00000080, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
